// File: rtl/hamming_frame_decoder.sv
// hamming_frame_decoder: serial 7E-headed frame receiver that de-interleaves and SEC-decodes 8 Hamming(7,4) codewords
module hamming_frame_decoder (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        data_in,
  input  logic        data_valid,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  output logic [7:0]  corr_flags,
  output logic        locked
);
  localparam logic [7:0] HEADER = 8'h7E;
  typedef enum logic [1:0] {HUNT, COLLECT, DECODE} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_hunt, w_hunt_sh;
  logic [55:0] r_pay;
  logic [5:0]  r_cnt;
  logic [31:0] w_word;
  logic [7:0]  w_flags;
  assign w_hunt_sh = {r_hunt[6:0], data_in};
  always_ff @(posedge clk_in or posedge rst)
    if (rst) r_state <= HUNT;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      HUNT:    w_next = (data_valid && w_hunt_sh == HEADER) ? COLLECT : HUNT;
      COLLECT: w_next = (data_valid && r_cnt == 6'd55) ? DECODE : COLLECT;
      default: w_next = HUNT;
    endcase
  end
  always_comb begin
    locked = (r_state == COLLECT) || (r_state == DECODE);
  end
  // r_pay[i] ends up holding frame bit f[i]; the hunt register keeps shifting in DECODE so back-to-back headers are not lost
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      r_hunt         <= '0;
      r_pay          <= '0;
      r_cnt          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      corr_flags     <= '0;
    end else begin
      data_out_valid <= r_state == DECODE;
      if (r_state == DECODE) begin
        data_out   <= w_word;
        corr_flags <= w_flags;
      end
      if (data_valid && r_state != COLLECT) r_hunt <= (w_next == COLLECT) ? 8'd0 : w_hunt_sh;
      if (data_valid && r_state == COLLECT) begin
        r_pay <= {r_pay[54:0], data_in};
        r_cnt <= r_cnt + 6'd1;
      end
      if (r_state == HUNT && w_next == COLLECT) r_cnt <= '0;
    end
  // codeword n bit i sits at frame bit 8i+n
  for (genvar n = 0; n < 8; n++) begin : g_cw
    logic [6:0] w_c, w_f;
    logic [2:0] w_s;
    assign w_c = {r_pay[48+n], r_pay[40+n], r_pay[32+n], r_pay[24+n], r_pay[16+n], r_pay[8+n], r_pay[n]};
    assign w_s = {w_c[3] ^ w_c[4] ^ w_c[5] ^ w_c[6],
                  w_c[1] ^ w_c[2] ^ w_c[5] ^ w_c[6],
                  w_c[0] ^ w_c[2] ^ w_c[4] ^ w_c[6]};
    assign w_f = w_c ^ ((w_s != 3'd0) ? (7'd1 << (w_s - 3'd1)) : 7'd0);
    assign w_word[4*n +: 4] = {w_f[6:4], w_f[2]};
    assign w_flags[n] = |w_s;
  end
endmodule

// File: tb/tb_hamming_frame_decoder.sv
// tb_hamming_frame_decoder: directed frame vectors plus back-to-back, gap and mid-frame reset sequences
module tb_hamming_frame_decoder;
  logic        clk_in = 1'b0;
  logic        rst, data_in, data_valid;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic [7:0]  corr_flags;
  logic        locked;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    int          pre;
    logic [31:0] word;
    logic [63:0] flip;
    logic [31:0] ew;
    logic [7:0]  ef;
  } vec_t;
  typedef struct {
    logic [31:0] w;
    logic [7:0]  f;
    int          c;
  } pulse_t;
  pulse_t pq[$];
  vec_t   vt[8];
  hamming_frame_decoder dut (
    .clk_in(clk_in),
    .rst(rst),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .corr_flags(corr_flags),
    .locked(locked)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(posedge clk_in) begin
    #1;
    if (data_out_valid) pq.push_back('{data_out, corr_flags, cyc});
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] enc(input logic [31:0] w);
    logic [63:0] f;
    logic [6:0]  c;
    logic [3:0]  d;
    f = '0;
    f[63:56] = 8'h7E;
    for (int n = 0; n < 8; n++) begin
      d = w[4*n +: 4];
      c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
      for (int i = 0; i < 7; i++) f[8*i+n] = c[i];
    end
    return f;
  endfunction
  // preamble bits follow a 110 pattern, which never contains a 7E window alone or joined to the header
  task automatic send_frame(input logic [63:0] f, input int pre, input bit gaps, output int hdr_cyc, output int lock_err);
    lock_err = 0;
    hdr_cyc = 0;
    for (int i = 0; i < pre; i++) begin
      @(negedge clk_in);
      if (locked !== 1'b0) lock_err++;
      data_in = (i % 3 != 2);
      data_valid = 1'b1;
    end
    for (int i = 63; i >= 0; i--) begin
      if (gaps && i < 63)
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clk_in);
          data_in = 1'($urandom_range(0, 1));
          data_valid = 1'b0;
        end
      @(negedge clk_in);
      if (i <= 62 && i >= 56 && locked !== 1'b0) lock_err++;
      if (i <= 55 && locked !== 1'b1) lock_err++;
      if (i == 56) hdr_cyc = cyc + 1;
      data_in = f[i];
      data_valid = 1'b1;
    end
  endtask
  task automatic wait_pulses(input int n);
    int t = 0;
    @(negedge clk_in);
    data_valid = 1'b0;
    while (pq.size() < n && t < 100) begin
      @(negedge clk_in);
      t++;
    end
  endtask
  initial begin
    int hc, le, hc2, le2;
    logic [63:0] f;
    vt[0] = '{0,  32'hDEADBEEF, 64'h0,                  32'hDEADBEEF, 8'h00};
    vt[1] = '{0,  32'hDEADBEEF, 64'h1,                  32'hDEADBEEF, 8'h01};
    vt[2] = '{0,  32'hDEADBEEF, 64'h1 << 20,            32'hDEADBEEF, 8'h10};
    vt[3] = '{0,  32'h12345678, 64'h00FF_0000_0000_0000, 32'h12345678, 8'hFF};
    vt[4] = '{13, 32'h0000FFFF, 64'h0,                  32'h0000FFFF, 8'h00};
    vt[5] = '{0,  32'h0FFFFFF0, 64'h0,                  32'h0FFFFFF0, 8'h00};
    vt[6] = '{3,  32'h89ABCDEF, 64'h1 << 47,            32'h89ABCDEF, 8'h80};
    vt[7] = '{0,  32'h00000000, 64'h1 << 27,            32'h00000000, 8'h08};
    rst = 1'b1;
    data_in = 1'b0;
    data_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    check("reset data_out", data_out, 0);
    check("reset valid", data_out_valid, 0);
    check("reset flags", corr_flags, 0);
    check("reset locked", locked, 0);
    for (int v = 0; v < 8; v++) begin
      pq.delete();
      f = enc(vt[v].word) ^ vt[v].flip;
      send_frame(f, vt[v].pre, 1'b0, hc, le);
      wait_pulses(1);
      check($sformatf("v%0d lock", v), le, 0);
      check($sformatf("v%0d pulses", v), pq.size(), 1);
      if (pq.size() > 0) begin
        check($sformatf("v%0d word", v), pq[0].w, vt[v].ew);
        check($sformatf("v%0d flags", v), pq[0].f, vt[v].ef);
        check($sformatf("v%0d latency", v), pq[0].c, hc + 57);
      end
      repeat (10) @(negedge clk_in);
      check($sformatf("v%0d hold", v), data_out, vt[v].ew);
      check($sformatf("v%0d extra", v), pq.size(), 1);
    end
    pq.delete();
    send_frame(enc(32'hA5A5A5A5), 0, 1'b0, hc, le);
    send_frame(enc(32'h5A5A5A5A), 0, 1'b1, hc2, le2);
    wait_pulses(2);
    check("b2b lock", le + le2, 0);
    check("b2b pulses", pq.size(), 2);
    if (pq.size() == 2) begin
      check("b2b word0", pq[0].w, 32'hA5A5A5A5);
      check("b2b latency0", pq[0].c, hc + 57);
      check("b2b word1", pq[1].w, 32'h5A5A5A5A);
      check("b2b flags1", pq[1].f, 8'h00);
    end
    pq.delete();
    f = enc(32'h11111111);
    for (int i = 63; i >= 26; i--) begin
      @(negedge clk_in);
      data_in = f[i];
      data_valid = 1'b1;
    end
    @(negedge clk_in);
    rst = 1'b1;
    data_valid = 1'b0;
    #1;
    check("rst locked", locked, 0);
    check("rst data_out", data_out, 0);
    check("rst valid", data_out_valid, 0);
    check("rst flags", corr_flags, 0);
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    repeat (5) @(negedge clk_in);
    check("abort pulses", pq.size(), 0);
    check("abort locked", locked, 0);
    send_frame(enc(32'hCAFEF00D), 0, 1'b0, hc, le);
    wait_pulses(1);
    check("post-rst pulses", pq.size(), 1);
    check("post-rst word", data_out, 32'hCAFEF00D);
    check("post-rst flags", corr_flags, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
